// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker for the Galois LFSR generator's serial output.
// Hunts for lock on received data, then flywheels a local predictor and counts bit errors.
module lfsr_checker #(
  parameter int              NBITS       = 8,
  parameter logic [NBITS-1:0] TAPS       = 8'b11101,
  parameter bit              INVERT      = 1'b0,
  parameter int              LOCK_COUNT  = 16,
  parameter int              WINDOW      = 64,
  parameter int              UNLOCK_ERRS = 8,
  parameter int              CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_count,
  output logic             locked,
  output logic             bit_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int FW = $clog2(NBITS + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(WINDOW + 1);

  localparam logic [FW-1:0] FILL_FULL  = FW'(NBITS);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic          INV_BIT    = INVERT & (^TAPS);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state;
  logic [NBITS-1:0] hist;
  logic [FW-1:0]    fill;
  logic [MW-1:0]    match;
  logic [WW-1:0]    win;
  logic [WW-1:0]    werr;

  logic             pred;
  logic             mismatch;
  logic [WW-1:0]    werr_next;
  logic [CNT_W-1:0] err_base;
  logic [CNT_W-1:0] err_next;

  // hist[0] is the oldest bit, so TAPS bit i weights the bit received i steps after it.
  assign pred      = (^(TAPS & hist)) ^ INV_BIT;
  assign mismatch  = in_bit ^ pred;
  assign werr_next = werr + WW'(mismatch);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    err_base = clear_count ? '0 : err_count;
    err_next = err_base;
    if (state == LOCKED && in_valid && mismatch && err_base != '1)
      err_next = err_base + CNT_W'(1);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      hist      <= '0;
      fill      <= '0;
      match     <= '0;
      win       <= '0;
      werr      <= '0;
      locked    <= 1'b0;
      bit_err   <= 1'b0;
      err_count <= '0;
    end else begin
      bit_err   <= 1'b0;
      err_count <= err_next;
      if (in_valid) begin
        case (state)
          HUNT: begin
            hist <= {in_bit, hist[NBITS-1:1]};
            if (fill < FILL_FULL) begin
              fill <= fill + FW'(1);
            end else if (!mismatch && hist != '0) begin
              if (match == MATCH_LAST) begin
                state  <= LOCKED;
                locked <= 1'b1;
                match  <= '0;
                win    <= '0;
                werr   <= '0;
              end else begin
                match <= match + MW'(1);
              end
            end else begin
              match <= '0;
            end
          end

          LOCKED: begin
            // Flywheel on the prediction so a single line error is not re-injected.
            hist    <= {pred, hist[NBITS-1:1]};
            bit_err <= mismatch;
            if (win == WIN_LAST) begin
              win  <= '0;
              werr <= '0;
              if (32'(werr_next) >= UNLOCK_ERRS) begin
                state  <= HUNT;
                locked <= 1'b0;
                fill   <= '0;
                match  <= '0;
              end
            end else begin
              win  <= win + WW'(1);
              werr <= werr_next;
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a Galois generator drives directed scenarios,
// expected outputs are queued per cycle and compared by an independent monitor.
module tb_lfsr_checker;

  localparam logic [7:0] TAPS = 8'b11101;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clear_count = 1'b0;
  logic        locked;
  logic        bit_err;
  logic [15:0] err_count;

  lfsr_checker dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .clear_count (clear_count),
    .locked      (locked),
    .bit_err     (bit_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        l;
    logic        e;
    logic [15:0] c;
    int          test_no;
    int          bit_no;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] gst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  // Galois generator, left shift; the serial output is the MSB before the shift.
  task automatic gen_bit(output logic b);
    b   = gst[7];
    gst = {gst[6:0], 1'b0} ^ (b ? TAPS : 8'h00);
  endtask

  task automatic drive(input logic v, input logic b, input logic clr,
                       input logic el, input logic ee, input logic [15:0] ec,
                       input int t, input int k);
    exp_t x;
    @(posedge clk);
    #2;
    in_valid    = v;
    in_bit      = b;
    clear_count = clr;
    x.l = el; x.e = ee; x.c = ec; x.test_no = t; x.bit_no = k;
    sb.push_back(x);
  endtask

  task automatic do_reset(input int t);
    @(posedge clk);
    #2;
    in_valid    = 1'b0;
    clear_count = 1'b0;
    reset       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("t%0d_rst_locked", t), 32'(locked), 0);
    check($sformatf("t%0d_rst_bit_err", t), 32'(bit_err), 0);
    check($sformatf("t%0d_rst_err_count", t), 32'(err_count), 0);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: outputs of the cycle consumed at this edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("t%0d_b%0d_locked", e.test_no, e.bit_no), 32'(locked), 32'(e.l));
        check($sformatf("t%0d_b%0d_bit_err", e.test_no, e.bit_no), 32'(bit_err), 32'(e.e));
        check($sformatf("t%0d_b%0d_err_count", e.test_no, e.bit_no), 32'(err_count), 32'(e.c));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       b;
    int         k;
    logic [15:0] ec;

    // 1: clean stream, valid every cycle; lock after bit 24, no errors ever.
    do_reset(1);
    gst = 8'hFF;
    for (int i = 1; i <= 1024; i++) begin
      gen_bit(b);
      drive(1'b1, b, 1'b0, i >= 24, 1'b0, 16'd0, 1, i);
    end

    // 2: valid every other cycle with garbage on idle cycles; lock after 24 valid bits.
    do_reset(2);
    gst = 8'hFF;
    k = 0;
    for (int c = 0; c < 120; c++) begin
      if (c % 2 == 0) begin
        k++;
        gen_bit(b);
        drive(1'b1, b, 1'b0, k >= 24, 1'b0, 16'd0, 2, k);
      end else begin
        drive(1'b0, 1'b1, 1'b0, k >= 24, 1'b0, 16'd0, 2, k);
      end
    end

    // 3: single flipped bit at 100; one pulse, one count, lock held.
    do_reset(3);
    gst = 8'hFF;
    for (int i = 1; i <= 1000; i++) begin
      gen_bit(b);
      drive(1'b1, b ^ (i == 100), 1'b0, i >= 24, i == 100,
            (i >= 100) ? 16'd1 : 16'd0, 3, i);
    end

    // 4: invert from bit 40; errors 40..88, unlock at the window end, no relock.
    do_reset(4);
    gst = 8'hFF;
    for (int i = 1; i <= 300; i++) begin
      gen_bit(b);
      if (i < 40)       ec = 16'd0;
      else if (i <= 88) ec = 16'(i - 39);
      else              ec = 16'd49;
      drive(1'b1, b ^ (i >= 40), 1'b0, (i >= 24) && (i < 88),
            (i >= 40) && (i <= 88), ec, 4, i);
    end

    // 5: stuck-at-0 line never locks.
    do_reset(5);
    for (int i = 1; i <= 500; i++)
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 5, i);

    // 6: five errors, then clear together with a mismatch, then async reset.
    do_reset(6);
    gst = 8'hFF;
    for (int i = 1; i <= 36; i++) begin
      gen_bit(b);
      if (i <= 30)      drive(1'b1, b, 1'b0, i >= 24, 1'b0, 16'd0, 6, i);
      else if (i <= 35) drive(1'b1, ~b, 1'b0, 1'b1, 1'b1, 16'(i - 30), 6, i);
      else              drive(1'b1, ~b, 1'b1, 1'b1, 1'b1, 16'd1, 6, i);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 6, 37);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("t6_async_locked", 32'(locked), 0);
    check("t6_async_bit_err", 32'(bit_err), 0);
    check("t6_async_err_count", 32'(err_count), 0);

    begin
      int n = 0;
      while (sb.size() > 0 && n < 10) begin
        @(posedge clk);
        n++;
      end
      #2;
      check("scoreboard_drained", 32'(sb.size()), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
